// File: rtl/harz80_pkg.sv
// Shared harzbus types: request codes, slot-bridge FSM states and the idle read value.
package harz80_pkg;

    typedef enum logic [3:0] {
        HARZ80_NONE        = 4'd0,
        HARZ80_IO_WRITE    = 4'd1,
        HARZ80_IO_READ     = 4'd2,
        HARZ80_MEM_WRITE_1 = 4'd3,
        HARZ80_MEM_READ_1  = 4'd4
    } harz_req_t;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_SETUP,
        BR_STROBE,
        BR_HOLD
    } bridge_state_t;

    localparam logic [7:0] HB_READ_IDLE = 8'hFF;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/harz_cycle_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module harz_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/harzbus_slot_bridge.sv
// Turns one-shot harzbus requests into timed slot-bus cycles (setup, strobe, hold).
// Optional HARZBUS_BRIDGE_TIMEOUT_EN aborts strobes that slot_busy stretches too long.
//
// state     | meaning
// BR_IDLE   | waiting for a fresh request edge
// BR_SETUP  | address/qualifier valid, strobe not yet asserted
// BR_STROBE | rd or wr asserted, waiting for minimum width and slot_busy low
// BR_HOLD   | strobe dropped, address/qualifier held
module harzbus_slot_bridge
    import harz80_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int CLKDIV      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  hb_request,
    input  logic [15:0] hb_address,
    input  logic [7:0]  hb_write_data,
    output logic [7:0]  hb_read_data,
    output logic        hb_busy,
    output logic        slot_clock,
    output logic        slot_reset_n,
    output logic        slot_iorq,
    output logic        slot_merq,
    output logic        slot_rd,
    output logic        slot_wr,
    output logic [15:0] slot_a,
    output logic [7:0]  slot_write_d,
    input  logic [7:0]  slot_read_d,
    input  logic        slot_busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);
    localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV / 2) : 1;
`ifdef HARZBUS_BRIDGE_TIMEOUT_EN
    localparam int STROBE_LOAD = TIMEOUT_CYC - 1;
`else
    localparam int STROBE_LOAD = STROBE_CYC - 1;
`endif

    bridge_state_t state;
    logic [3:0]    req_eff;
    logic [3:0]    req_prev;
    logic          accept;
    logic          req_is_io;
    logic          req_is_read;
    logic          is_read_q;
    logic          min_elapsed;
    logic          strobe_done;
    logic          timed_out;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_count;
    logic          tmr_zero;
    logic [DW-1:0] div_cnt;

    // Unknown codes behave exactly like NONE, including for edge detection.
    always_comb begin
        req_eff     = (hb_request > 4'(HARZ80_MEM_READ_1)) ? 4'(HARZ80_NONE) : hb_request;
        accept      = (state == BR_IDLE) && (req_eff != 4'(HARZ80_NONE))
                      && (req_prev == 4'(HARZ80_NONE));
        req_is_io   = (req_eff == 4'(HARZ80_IO_WRITE)) || (req_eff == 4'(HARZ80_IO_READ));
        req_is_read = (req_eff == 4'(HARZ80_IO_READ)) || (req_eff == 4'(HARZ80_MEM_READ_1));
    end

    // With the timeout, the strobe timer counts down from TIMEOUT_CYC, so the
    // minimum width is reached once the count has dropped by STROBE_CYC.
`ifdef HARZBUS_BRIDGE_TIMEOUT_EN
    assign min_elapsed = (tmr_count <= CW'(TIMEOUT_CYC - STROBE_CYC));
    assign timed_out   = tmr_zero && slot_busy;
`else
    assign min_elapsed = tmr_zero;
    assign timed_out   = 1'b0;
`endif
    assign strobe_done = min_elapsed && !slot_busy;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            BR_IDLE:   if (accept) begin
                           tmr_load = 1'b1;
                           tmr_val  = CW'(SETUP_CYC - 1);
                       end
            BR_SETUP:  if (tmr_zero) begin
                           tmr_load = 1'b1;
                           tmr_val  = CW'(STROBE_LOAD);
                       end
            BR_STROBE: if (strobe_done || timed_out) begin
                           tmr_load = 1'b1;
                           tmr_val  = CW'(HOLD_CYC - 1);
                       end
            default:   ;
        endcase
    end

    harz_cycle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BR_IDLE;
            req_prev     <= 4'(HARZ80_NONE);
            is_read_q    <= 1'b0;
            hb_busy      <= 1'b0;
            hb_read_data <= HB_READ_IDLE;
            slot_iorq    <= 1'b0;
            slot_merq    <= 1'b0;
            slot_rd      <= 1'b0;
            slot_wr      <= 1'b0;
            slot_a       <= '0;
            slot_write_d <= '0;
            timeout_err  <= 1'b0;
        end else begin
            req_prev <= req_eff;
            case (state)
                BR_IDLE: if (accept) begin
                    state        <= BR_SETUP;
                    hb_busy      <= 1'b1;
                    is_read_q    <= req_is_read;
                    slot_a       <= hb_address;
                    slot_write_d <= hb_write_data;
                    slot_iorq    <= req_is_io;
                    slot_merq    <= !req_is_io;
                end
                BR_SETUP: if (tmr_zero) begin
                    state   <= BR_STROBE;
                    slot_rd <= is_read_q;
                    slot_wr <= !is_read_q;
                end
                BR_STROBE: if (strobe_done || timed_out) begin
                    state   <= BR_HOLD;
                    slot_rd <= 1'b0;
                    slot_wr <= 1'b0;
                    if (is_read_q)
                        hb_read_data <= timed_out ? HB_READ_IDLE : slot_read_d;
                    if (timed_out)
                        timeout_err <= 1'b1;
                end
                BR_HOLD: if (tmr_zero) begin
                    state     <= BR_IDLE;
                    hb_busy   <= 1'b0;
                    slot_iorq <= 1'b0;
                    slot_merq <= 1'b0;
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            slot_clock <= 1'b0;
        end else if (div_cnt == DW'(CLKDIV / 2 - 1)) begin
            div_cnt    <= '0;
            slot_clock <= !slot_clock;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        slot_reset_n <= !reset;
    end

endmodule

// File: tb/tb_harzbus_slot_bridge.sv
// Randomized bench for harzbus_slot_bridge against a cycle-budget reference model.
module tb_harzbus_slot_bridge;
    import harz80_pkg::*;

    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
    localparam int CD = 2;
    localparam int T  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hb_request;
    logic [15:0] hb_address;
    logic [7:0]  hb_write_data;
    logic [7:0]  hb_read_data;
    logic        hb_busy;
    logic        slot_clock;
    logic        slot_reset_n;
    logic        slot_iorq;
    logic        slot_merq;
    logic        slot_rd;
    logic        slot_wr;
    logic [15:0] slot_a;
    logic [7:0]  slot_write_d;
    logic [7:0]  slot_read_d;
    logic        slot_busy;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rd_model  = 8'hFF;
    logic       err_model = 1'b0;

    harzbus_slot_bridge #(
        .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .CLKDIV(CD), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .reset(reset),
        .hb_request(hb_request), .hb_address(hb_address), .hb_write_data(hb_write_data),
        .hb_read_data(hb_read_data), .hb_busy(hb_busy),
        .slot_clock(slot_clock), .slot_reset_n(slot_reset_n),
        .slot_iorq(slot_iorq), .slot_merq(slot_merq), .slot_rd(slot_rd), .slot_wr(slot_wr),
        .slot_a(slot_a), .slot_write_d(slot_write_d), .slot_read_d(slot_read_d),
        .slot_busy(slot_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Device model: holds slot_busy until the strobe has lasted ST+extra cycles.
    // The expected trace is derived from cycle budgets: S setup, L strobe, H hold.
    task automatic run_txn(input logic [3:0] code, input logic [15:0] addr,
                           input logic [7:0] wdat, input logic [7:0] rdat,
                           input int extra, input int req_len, input bit poke);
        int  L, total, sc;
        bit  is_io, is_rd, to, busy_e, strobe_e;
        is_io = (code == HARZ80_IO_WRITE) || (code == HARZ80_IO_READ);
        is_rd = (code == HARZ80_IO_READ) || (code == HARZ80_MEM_READ_1);
        L  = ST + extra;
        to = 1'b0;
`ifdef HARZBUS_BRIDGE_TIMEOUT_EN
        if (L > T) begin
            L  = T;
            to = 1'b1;
        end
`endif
        total = S + L + H;
        @(negedge clk);
        hb_request    = code;
        hb_address    = addr;
        hb_write_data = wdat;
        slot_read_d   = rdat;
        slot_busy     = 1'b0;
        sc            = 0;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            busy_e   = (c <= total);
            strobe_e = (c > S) && (c <= S + L);
            chk_val("ctl{busy,iorq,merq,rd,wr}",
                    {hb_busy, slot_iorq, slot_merq, slot_rd, slot_wr},
                    {busy_e, busy_e && is_io, busy_e && !is_io,
                     strobe_e && is_rd, strobe_e && !is_rd});
            if (c == S + 1 || c == total) begin
                chk_val("slot_a", slot_a, addr);
                if (!is_rd) chk_val("slot_write_d", slot_write_d, wdat);
            end
            if (slot_rd || slot_wr) sc++;
            slot_busy  = (slot_rd || slot_wr) && (sc < ST + extra);
            hb_request = (c < req_len && !(poke && c == 2)) ? code : 4'(HARZ80_NONE);
        end
        hb_request = 4'(HARZ80_NONE);
        slot_busy  = 1'b0;
        if (is_rd) rd_model = to ? 8'hFF : rdat;
        err_model = err_model | to;
        chk_val("hb_read_data", hb_read_data, rd_model);
        chk_val("timeout_err", timeout_err, err_model);
    endtask

    initial begin
        int  c;
        reset         = 1'b1;
        hb_request    = 4'(HARZ80_NONE);
        hb_address    = '0;
        hb_write_data = '0;
        slot_read_d   = '0;
        slot_busy     = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_ctl", {hb_busy, slot_iorq, slot_merq, slot_rd, slot_wr}, 5'b0);
        chk_val("rst_read_data", hb_read_data, 8'hFF);
        chk_val("rst_addr_data", {slot_a, slot_write_d}, 24'h0);
        chk_val("rst_clk_rstn", {slot_clock, slot_reset_n, timeout_err}, 3'b000);

        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk_val("slot_clock", slot_clock, 32'((k / (CD / 2)) % 2));
            chk_val("slot_reset_n", slot_reset_n, 1);
        end

        run_txn(4'(HARZ80_IO_WRITE), 16'h00A0, 8'h07, 8'h00, 0, 2, 1'b0);
        run_txn(4'(HARZ80_MEM_READ_1), 16'h9800, 8'h00, 8'h5A, 3, 1, 1'b0);
        run_txn(4'(HARZ80_IO_READ), 16'h00A2, 8'h00, 8'h3C, 0, 20, 1'b1);

        @(negedge clk);
        hb_request = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_val("bad_code_ctl", {hb_busy, slot_iorq, slot_merq, slot_rd, slot_wr}, 5'b0);
        end
        hb_request = 4'(HARZ80_NONE);

        // Reset during the strobe of a memory write.
        @(negedge clk);
        hb_request    = 4'(HARZ80_MEM_WRITE_1);
        hb_address    = 16'h4000;
        hb_write_data = 8'hC3;
        c = 0;
        while (!slot_wr && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk_val("reach_strobe", slot_wr, 1);
        reset      = 1'b1;
        hb_request = 4'(HARZ80_NONE);
        @(negedge clk);
        chk_val("midrst_ctl", {hb_busy, slot_iorq, slot_merq, slot_rd, slot_wr}, 5'b0);
        chk_val("midrst_read_data", hb_read_data, 8'hFF);
        chk_val("midrst_rstn", slot_reset_n, 0);
        reset     = 1'b0;
        rd_model  = 8'hFF;
        err_model = 1'b0;
        @(negedge clk);
        chk_val("post_rst_idle", hb_busy, 0);

`ifdef HARZBUS_BRIDGE_TIMEOUT_EN
        run_txn(4'(HARZ80_IO_READ), 16'h00A2, 8'h00, 8'h77, 100, 3, 1'b0);
        run_txn(4'(HARZ80_IO_WRITE), 16'h0011, 8'h22, 8'h00, 0, 2, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            logic [3:0] code;
            code = 4'($urandom_range(1, 4));
            run_txn(code, 16'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 4), $urandom_range(1, 12), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
